mem_bist: RTL and testbench

- Memory-side initiator that drives the single-port data memory interface (Address, DataIn, MemWrite, clocked MemVal).
- On Start, writes a selectable data pattern over a strided address range, reads the range back, compares every word and reports pass/fail, error count and first failing address.
- Used for post-reset memory self-test and as a bus master for memory bring-up, in place of hand-driven address loops.

---
 rtl/mem_bist.sv | 173 +++++++++++++++++
 tb/tb_mem_bist.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// rtl/mem_bist.sv - memory BIST initiator: pattern write over a strided range, pipelined read-back and compare
// Outputs are registered from next-state values so they stay aligned with the state they belong to.
module mem_bist #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int STRIDE = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-1:0] WordCount,
  input  logic [1:0]        PatternSel,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataOut,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemVal,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [15:0]       ErrCount,
  output logic [ADDR_W-1:0] FirstErrAddr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [DATA_W-1:0] CHECKER = {(DATA_W/2){2'b10}};

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [15:0] i);
    logic [31:0] off;
    off = 32'(i) * 32'(STRIDE);
    return base + ADDR_W'(off);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] sel, input logic [15:0] i,
                                                input logic [ADDR_W-1:0] addr);
    case (sel)
      2'd0:    return DATA_W'(i);
      2'd1:    return ~DATA_W'(i);
      2'd2:    return i[0] ? ~CHECKER : CHECKER;
      default: return DATA_W'(addr);
    endcase
  endfunction

  state_t            state, state_nx;
  logic [15:0]       idx, idx_nx;
  logic [ADDR_W-1:0] base_l, count_l;
  logic [1:0]        sel_l;
  logic              cmp_valid, cmp_valid_nx;
  logic [DATA_W-1:0] cmp_exp, cmp_exp_nx;
  logic [ADDR_W-1:0] cmp_addr, cmp_addr_nx;

  logic [ADDR_W-1:0] mem_addr_nx, first_nx;
  logic [DATA_W-1:0] mem_data_nx;
  logic              mem_write_nx, busy_nx, done_nx, pass_nx;
  logic [15:0]       err_nx;

  logic              start_ok, abort_ok, last, mismatch;
  logic [ADDR_W-1:0] base_src, launch_addr;
  logic [1:0]        sel_src;

  assign start_ok = (state == IDLE) && Start;
  assign abort_ok = (state != IDLE) && Abort;
  assign last     = (ADDR_W'(idx) == count_l - ADDR_W'(1));
  assign mismatch = cmp_valid && !abort_ok && (MemVal != cmp_exp);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      base_l       <= '0;
      count_l      <= '0;
      sel_l        <= '0;
      cmp_valid    <= 1'b0;
      cmp_exp      <= '0;
      cmp_addr     <= '0;
      MemAddress   <= '0;
      MemDataOut   <= '0;
      MemWrite     <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Pass         <= 1'b0;
      ErrCount     <= '0;
      FirstErrAddr <= '0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      if (start_ok) begin
        base_l  <= BaseAddr;
        count_l <= WordCount;
        sel_l   <= PatternSel;
      end
      cmp_valid    <= cmp_valid_nx;
      cmp_exp      <= cmp_exp_nx;
      cmp_addr     <= cmp_addr_nx;
      MemAddress   <= mem_addr_nx;
      MemDataOut   <= mem_data_nx;
      MemWrite     <= mem_write_nx;
      Busy         <= busy_nx;
      Done         <= done_nx;
      Pass         <= pass_nx;
      ErrCount     <= err_nx;
      FirstErrAddr <= first_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nx = (WordCount == '0) ? DONE : WRITE;
          idx_nx   = '0;
        end
      end
      WRITE: begin
        if (last) begin
          state_nx = READ;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 16'd1;
        end
      end
      READ: begin
        if (last) state_nx = DRAIN;
        else      idx_nx   = idx + 16'd1;
      end
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_ok) state_nx = IDLE;
  end

  // Launch values come straight from the inputs on the Start edge, before the latches hold them.
  always_comb begin
    base_src     = start_ok ? BaseAddr : base_l;
    sel_src      = start_ok ? PatternSel : sel_l;
    launch_addr  = word_addr(base_src, idx_nx);

    mem_write_nx = (state_nx == WRITE);
    mem_addr_nx  = MemAddress;
    mem_data_nx  = MemDataOut;
    if (state_nx == WRITE || state_nx == READ) mem_addr_nx = launch_addr;
    if (state_nx == WRITE) mem_data_nx = pattern(sel_src, idx_nx, launch_addr);

    busy_nx = (state_nx == WRITE) || (state_nx == READ) || (state_nx == DRAIN);
    done_nx = (state_nx == DONE);

    cmp_valid_nx = (state == READ) && !abort_ok;
    cmp_addr_nx  = word_addr(base_l, idx);
    cmp_exp_nx   = pattern(sel_l, idx, cmp_addr_nx);

    err_nx   = ErrCount;
    first_nx = FirstErrAddr;
    if (start_ok) begin
      err_nx   = '0;
      first_nx = '0;
    end else if (mismatch) begin
      if (ErrCount != 16'hFFFF) err_nx = ErrCount + 16'd1;
      if (ErrCount == 16'd0)    first_nx = cmp_addr;
    end

    pass_nx = Pass;
    if (start_ok) pass_nx = 1'b0;
    if (abort_ok) pass_nx = 1'b0;
    else if (state_nx == DONE) pass_nx = (err_nx == 16'd0);
  end

endmodule

// File: tb/tb_mem_bist.sv
// tb/tb_mem_bist.sv - directed bench for mem_bist with a synchronous-read memory model
module tb_mem_bist;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        Start, Abort;
  logic [15:0] BaseAddr, WordCount;
  logic [1:0]  PatternSel;
  logic [15:0] MemAddress, MemDataOut, MemVal;
  logic        MemWrite, Busy, Done, Pass;
  logic [15:0] ErrCount, FirstErrAddr;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] stuck_mask = 16'h0000;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];

  int done_cyc, busy_cyc, done_n;
  logic busy_post, pass_post, done_post, mw_post;

  mem_bist #(.ADDR_W(16), .DATA_W(16), .STRIDE(4)) dut (
    .clock(clock), .reset_n(reset_n), .Start(Start), .Abort(Abort),
    .BaseAddr(BaseAddr), .WordCount(WordCount), .PatternSel(PatternSel),
    .MemAddress(MemAddress), .MemDataOut(MemDataOut), .MemWrite(MemWrite),
    .MemVal(MemVal), .Busy(Busy), .Done(Done), .Pass(Pass),
    .ErrCount(ErrCount), .FirstErrAddr(FirstErrAddr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (MemWrite) begin
      mem[MemAddress] <= MemDataOut;
      wr_addr.push_back(MemAddress);
      wr_data.push_back(MemDataOut);
    end
    MemVal <= mem[MemAddress] & ~stuck_mask;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [15:0] base, input logic [15:0] cnt, input logic [1:0] sel,
                     input int start_at, input int abort_at, input int limit);
    int cyc;
    wr_addr.delete();
    wr_data.delete();
    BaseAddr = base; WordCount = cnt; PatternSel = sel;
    Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    BaseAddr = 16'h1234; WordCount = 16'h0055; PatternSel = 2'd3;
    cyc = 1; done_cyc = 0; busy_cyc = 0; done_n = 0;
    while (1) begin
      if (Busy) busy_cyc++;
      if (Done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc == abort_at + 1) begin
        busy_post = Busy; pass_post = Pass; done_post = Done; mw_post = MemWrite;
      end
      if ((done_cyc != 0 && cyc >= done_cyc + 3) || cyc >= limit) break;
      Start = (cyc == start_at);
      Abort = (cyc == abort_at);
      @(posedge clock); #1;
      cyc++;
    end
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] exp_a [4];
    logic [15:0] exp_d [4];
    reset_n = 1'b0; Start = 1'b0; Abort = 1'b0;
    BaseAddr = '0; WordCount = '0; PatternSel = '0;
    repeat (2) @(posedge clock); #1;
    check("rst_addr", MemAddress, 0);
    check("rst_data", MemDataOut, 0);
    check("rst_mwrite", MemWrite, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_pass", Pass, 0);
    check("rst_errcnt", ErrCount, 0);
    check("rst_firsterr", FirstErrAddr, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // reset asserted in the middle of the write phase
    BaseAddr = 16'h0000; WordCount = 16'd64; PatternSel = 2'd0;
    Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    repeat (9) @(posedge clock); #1;
    check("midwr_mwrite_before", MemWrite, 1);
    reset_n = 1'b0;
    #1;
    check("midwr_mwrite", MemWrite, 0);
    check("midwr_busy", Busy, 0);
    check("midwr_addr", MemAddress, 0);
    check("midwr_data", MemDataOut, 0);
    n = wr_addr.size();
    @(posedge clock); #1;
    check("midwr_no_write", wr_addr.size(), n);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 64 words, index pattern
    run(16'h0000, 16'd64, 2'd0, 0, 0, 300);
    check("n64_done_cyc", done_cyc, 130);
    check("n64_busy_cyc", busy_cyc, 129);
    check("n64_done_n", done_n, 1);
    check("n64_pass", Pass, 1);
    check("n64_errcnt", ErrCount, 0);
    check("n64_firsterr", FirstErrAddr, 0);
    check("n64_nwr", wr_addr.size(), 64);
    for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
      check($sformatf("n64_wa%0d", i), wr_addr[i], i * 4);
      check($sformatf("n64_wd%0d", i), wr_data[i], i);
    end

    // checkerboard with address wrap
    run(16'hFFF8, 16'd4, 2'd2, 0, 0, 50);
    exp_a = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
    exp_d = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
    check("cb_nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check($sformatf("cb_wa%0d", i), wr_addr[i], exp_a[i]);
      check($sformatf("cb_wd%0d", i), wr_data[i], exp_d[i]);
    end
    check("cb_done_cyc", done_cyc, 10);
    check("cb_pass", Pass, 1);

    // address pattern and inverted index
    run(16'h0100, 16'd3, 2'd3, 0, 0, 50);
    check("ap_nwr", wr_addr.size(), 3);
    for (int i = 0; i < 3 && i < wr_data.size(); i++)
      check($sformatf("ap_wd%0d", i), wr_data[i], 16'h0100 + i * 4);
    check("ap_pass", Pass, 1);
    run(16'h0000, 16'd2, 2'd1, 0, 0, 50);
    check("inv_nwr", wr_data.size(), 2);
    if (wr_data.size() == 2) begin
      check("inv_wd0", wr_data[0], 16'hFFFF);
      check("inv_wd1", wr_data[1], 16'hFFFE);
    end
    check("inv_pass", Pass, 1);

    // bit 3 stuck at 0
    stuck_mask = 16'h0008;
    run(16'h0000, 16'd16, 2'd0, 0, 0, 100);
    check("stk_done_cyc", done_cyc, 34);
    check("stk_errcnt", ErrCount, 8);
    check("stk_firsterr", FirstErrAddr, 16'h0020);
    check("stk_pass", Pass, 0);
    stuck_mask = 16'h0000;

    // zero-length test
    run(16'h0040, 16'd0, 2'd0, 0, 0, 20);
    check("z_nwr", wr_addr.size(), 0);
    check("z_done_cyc", done_cyc, 1);
    check("z_busy_cyc", busy_cyc, 0);
    check("z_done_n", done_n, 1);
    check("z_pass", Pass, 1);

    // Start pulsed while busy
    run(16'h0200, 16'd10, 2'd0, 5, 0, 100);
    check("sb_done_n", done_n, 1);
    check("sb_done_cyc", done_cyc, 22);
    check("sb_nwr", wr_addr.size(), 10);
    check("sb_pass", Pass, 1);

    // Abort during READ of a 32-word test with errors already counted
    stuck_mask = 16'h0008;
    run(16'h0000, 16'd32, 2'd0, 0, 50, 120);
    check("ab_busy_next", busy_post, 0);
    check("ab_pass_next", pass_post, 0);
    check("ab_done_next", done_post, 0);
    check("ab_mwrite_next", mw_post, 0);
    check("ab_done_n", done_n, 0);
    check("ab_nwr", wr_addr.size(), 32);
    check("ab_errcnt", ErrCount, 8);
    check("ab_firsterr", FirstErrAddr, 16'h0020);
    check("ab_mwrite_end", MemWrite, 0);
    stuck_mask = 16'h0000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
